// File: rtl/mealy_pack_pkg.sv
// Shared types and sizes for the Mealy detector result packer.
// The packed word carries one x bit and one y bit per sample plus a fill length.
package mealy_pack_pkg;

   localparam int SAMPLES    = 11;
   localparam int FIFO_DEPTH = 4;
   localparam int LENW       = $clog2(SAMPLES + 1);

   typedef struct packed {
      logic [SAMPLES-1:0] x;
      logic [SAMPLES-1:0] y;
      logic [LENW-1:0]    len;
   } packed_word_t;

   typedef enum logic {
      ST_EMPTY   = 1'b0,
      ST_FILLING = 1'b1
   } pack_state_t;

   // True when the sample that is being added makes the word complete.
   function automatic logic is_last_slot(input logic [LENW-1:0] fill_cnt);
      return fill_cnt == LENW'(SAMPLES - 1);
   endfunction

endpackage

// File: rtl/mealy_pack_fifo.sv
// Small synchronous first-word-fall-through FIFO of packed words.
// A push while full is only accepted when a pop frees a slot on the same edge.
module mealy_pack_fifo
   import mealy_pack_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  packed_word_t push_data,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic         push_accepted,
   output packed_word_t head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr_reg;
   logic [AW:0]  rd_ptr_reg;
   logic [AW:0]  wr_ptr_next;
   logic [AW:0]  rd_ptr_next;
   logic         do_pop;
   packed_word_t mem [DEPTH];

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

   assign do_pop        = pop && !empty;
   assign push_accepted = push && (!full || do_pop);

   assign wr_ptr_next = push_accepted ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
   assign rd_ptr_next = do_pop        ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push_accepted) begin
         mem[wr_ptr_reg[AW-1:0]] <= push_data;
      end
   end

   assign head = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/mealy_result_packer.sv
// Packs the detector's doutx/douty pairs into SAMPLES-wide words, first sample in MSB,
// and queues completed or flushed words for a valid/ready consumer.
module mealy_result_packer
   import mealy_pack_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic               doutx,
   input  logic               douty,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SAMPLES-1:0] out_x,
   output logic [SAMPLES-1:0] out_y,
   output logic [LENW-1:0]    out_len,
   output logic               overflow
);

   pack_state_t        state_reg;
   pack_state_t        state_next;
   logic [LENW-1:0]    fill_cnt_reg;
   logic [LENW-1:0]    fill_cnt_next;
   logic [SAMPLES-1:0] x_sr_reg;
   logic [SAMPLES-1:0] x_sr_next;
   logic [SAMPLES-1:0] y_sr_reg;
   logic [SAMPLES-1:0] y_sr_next;
   logic               overflow_reg;

   logic [SAMPLES-1:0] slot_hit;
   logic [SAMPLES-1:0] x_word;
   logic [SAMPLES-1:0] y_word;
   logic [LENW-1:0]    len_word;
   logic               close_word;

   logic               push_valid;
   packed_word_t       push_word;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_pop;
   logic               push_accepted;
   packed_word_t       fifo_head;

   // One-hot select of the bit position the next sample lands in.
   genvar gi;
   generate
      for (gi = 0; gi < SAMPLES; gi++) begin : g_slot
         assign slot_hit[gi] = (fill_cnt_reg == LENW'(SAMPLES - 1 - gi));
      end
   endgenerate

   // Word contents as they would look including this cycle's sample.
   always_comb begin
      x_word   = x_sr_reg;
      y_word   = y_sr_reg;
      len_word = fill_cnt_reg;
      if (in_valid) begin
         x_word   = x_sr_reg | ({SAMPLES{doutx}} & slot_hit);
         y_word   = y_sr_reg | ({SAMPLES{douty}} & slot_hit);
         len_word = fill_cnt_reg + 1'b1;
      end
   end

   // A flush only closes a word if it holds at least one sample after this cycle.
   assign close_word = (in_valid && is_last_slot(fill_cnt_reg)) ||
                       (flush && (state_reg == ST_FILLING || in_valid));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= ST_EMPTY;
         fill_cnt_reg <= '0;
         x_sr_reg     <= '0;
         y_sr_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         fill_cnt_reg <= fill_cnt_next;
         x_sr_reg     <= x_sr_next;
         y_sr_reg     <= y_sr_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      fill_cnt_next = fill_cnt_reg;
      x_sr_next     = x_sr_reg;
      y_sr_next     = y_sr_reg;
      if (close_word) begin
         state_next    = ST_EMPTY;
         fill_cnt_next = '0;
         x_sr_next     = '0;
         y_sr_next     = '0;
      end else if (in_valid) begin
         state_next    = ST_FILLING;
         fill_cnt_next = len_word;
         x_sr_next     = x_word;
         y_sr_next     = y_word;
      end
   end

   always_comb begin
      push_valid     = close_word;
      push_word.x    = x_word;
      push_word.y    = y_word;
      push_word.len  = len_word;
   end

   assign fifo_pop = out_ready && !fifo_empty;

   mealy_pack_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push         (push_valid),
      .push_data    (push_word),
      .pop          (fifo_pop),
      .full         (fifo_full),
      .empty        (fifo_empty),
      .push_accepted(push_accepted),
      .head         (fifo_head)
   );

   // Sticky: any word lost to a full queue is remembered until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_reg <= 1'b0;
      end else if (push_valid && !push_accepted) begin
         overflow_reg <= 1'b1;
      end
   end

   assign overflow  = overflow_reg;
   assign out_valid = !fifo_empty;
   assign out_x     = fifo_empty ? '0 : fifo_head.x;
   assign out_y     = fifo_empty ? '0 : fifo_head.y;
   assign out_len   = fifo_empty ? '0 : fifo_head.len;

endmodule

// File: tb/tb_mealy_result_packer.sv
// Randomised and directed checks of the result packer against a queue-based model.
// Model builds words from a list of sample bits and tracks the queue as a bounded list.
module tb_mealy_result_packer;
   import mealy_pack_pkg::*;

   localparam int NS = SAMPLES;
   localparam int ND = FIFO_DEPTH;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            doutx;
   logic            douty;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [NS-1:0]   out_x;
   logic [NS-1:0]   out_y;
   logic [LENW-1:0] out_len;
   logic            overflow;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [NS-1:0] x;
      logic [NS-1:0] y;
      int            len;
   } word_t;

   bit    mx[$];
   bit    my[$];
   word_t mq[$];
   bit    m_ovf;

   always #5 clk = ~clk;

   mealy_result_packer #(
      .DEPTH(ND)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .doutx    (doutx),
      .douty    (douty),
      .flush    (flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_x    (out_x),
      .out_y    (out_y),
      .out_len  (out_len),
      .overflow (overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      bit    pop;
      bit    have;
      word_t w;
      pop  = out_ready && (mq.size() != 0);
      have = 0;
      if (in_valid) begin
         mx.push_back(doutx);
         my.push_back(douty);
      end
      if (mx.size() != 0 && (mx.size() == NS || flush)) begin
         w.x = '0;
         w.y = '0;
         for (int i = 0; i < mx.size(); i++) begin
            w.x[NS-1-i] = mx[i];
            w.y[NS-1-i] = my[i];
         end
         w.len = mx.size();
         mx.delete();
         my.delete();
         have = 1;
      end
      if (pop) begin
         $display("pop  x=%b y=%b len=%0d", mq[0].x, mq[0].y, mq[0].len);
         void'(mq.pop_front());
      end
      if (have) begin
         if (mq.size() < ND) mq.push_back(w);
         else m_ovf = 1;
      end
   endtask

   task automatic compare();
      check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) begin
         check("out_x", 32'(out_x), 32'(mq[0].x));
         check("out_y", 32'(out_y), 32'(mq[0].y));
         check("out_len", 32'(out_len), 32'(mq[0].len));
      end
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
   endtask

   task automatic step(input logic iv, input logic dx, input logic dy,
                       input logic fl, input logic rdy);
      in_valid  = iv;
      doutx     = dx;
      douty     = dy;
      flush     = fl;
      out_ready = rdy;
      model_edge();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic feed_word(input logic [NS-1:0] xv, input logic [NS-1:0] yv, input logic rdy);
      for (int i = 0; i < NS; i++) begin
         step(1'b1, xv[NS-1-i], yv[NS-1-i], 1'b0, rdy);
      end
   endtask

   // Reset is asserted mid-cycle so its asynchronous effect can be observed.
   task automatic apply_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      flush    = 1'b0;
      #2;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_x", 32'(out_x), 32'd0);
      check("rst_y", 32'(out_y), 32'd0);
      check("rst_len", 32'(out_len), 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      mx.delete();
      my.delete();
      mq.delete();
      m_ovf = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [NS-1:0] xv;
      logic [NS-1:0] yv;
      int            seen;

      reset     = 1'b1;
      in_valid  = 1'b0;
      doutx     = 1'b0;
      douty     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      m_ovf     = 0;
      @(posedge clk);
      #1;
      apply_reset();

      // Full word, ready high
      xv = 11'b01111111010;
      yv = 11'b00000001000;
      feed_word(xv, yv, 1'b1);
      check("t1_valid", {31'd0, out_valid}, 32'd1);
      check("t1_x", 32'(out_x), 32'(11'b01111111010));
      check("t1_y", 32'(out_y), 32'(11'b00000001000));
      check("t1_len", 32'(out_len), 32'd11);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Partial word closed by flush, then a flush with nothing pending
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("t2_x", 32'(out_x), 32'(11'b10100000000));
      check("t2_y", 32'(out_y), 32'(11'b01100000000));
      check("t2_len", 32'(out_len), 32'd3);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("t2_empty", {31'd0, out_valid}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Stalled consumer: five words, one lost
      for (int w = 0; w < 5; w++) begin
         feed_word(NS'($urandom), NS'($urandom), 1'b0);
      end
      check("t3_ovf", {31'd0, overflow}, 32'd1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t3_drained", {31'd0, out_valid}, 32'd0);

      // Full queue with push and pop on the same edge
      apply_reset();
      for (int w = 0; w < 4; w++) feed_word(NS'($urandom), NS'($urandom), 1'b0);
      for (int i = 0; i < NS - 1; i++) step(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      step(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b1);
      check("t4_ovf", {31'd0, overflow}, 32'd0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) seen++;
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      check("t4_count", 32'(seen), 32'd4);

      // Reset discards a partial word
      for (int i = 0; i < 6; i++) step(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b1);
      apply_reset();
      check("t5_novalid", {31'd0, out_valid}, 32'd0);
      xv = 11'b10000000001;
      yv = 11'b11000000011;
      feed_word(xv, yv, 1'b0);
      check("t5_x", 32'(out_x), 32'(11'b10000000001));
      check("t5_len", 32'(out_len), 32'd11);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Gaps mid-word, flush on the completing sample
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'(i & 1), 1'(i == 4), 1'b0, 1'b0);
         if (i == 3 || i == 7) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      end
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      check("t6_x", 32'(out_x), 32'(11'b01010101011));
      check("t6_y", 32'(out_y), 32'(11'b00001000000));
      check("t6_len", 32'(out_len), 32'd11);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t6_single", {31'd0, out_valid}, 32'd0);

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 399) == 0) apply_reset();
         step(1'($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom),
              1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 9) < 6));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
